// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: stall/flush request and control bundle between the pipeline and pipe_ctrl.
`ifndef N_INST_ADDR
`define N_INST_ADDR 32
`endif
interface pipe_ctrl_if #(parameter int N_INST_ADDR = `N_INST_ADDR);
    logic                   i_stallreq_if;
    logic                   i_stallreq_id;
    logic                   i_stallreq_ex;
    logic                   i_stallreq_mem;
    logic                   i_flush_req;
    logic [N_INST_ADDR-1:0] i_flush_pc;
    logic                   i_perf_clr;
    logic [5:0]             o_stall;
    logic                   o_flush;
    logic [N_INST_ADDR-1:0] o_new_pc;
    logic                   o_stall_timeout;
    logic [31:0]            o_perf_stall_cnt;
    modport master (
        output i_stallreq_if, i_stallreq_id, i_stallreq_ex, i_stallreq_mem,
        output i_flush_req, i_flush_pc, i_perf_clr,
        input  o_stall, o_flush, o_new_pc, o_stall_timeout, o_perf_stall_cnt
    );
    modport slave (
        input  i_stallreq_if, i_stallreq_id, i_stallreq_ex, i_stallreq_mem,
        input  i_flush_req, i_flush_pc, i_perf_clr,
        output o_stall, o_flush, o_new_pc, o_stall_timeout, o_perf_stall_cnt
    );
endinterface

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline stall/flush controller with stall watchdog.
// Define PIPE_CTRL_PERF_EN to enable the stalled-cycle performance counter.
`ifndef N_INST_ADDR
`define N_INST_ADDR 32
`endif
module pipe_ctrl #(
    parameter int N_INST_ADDR   = `N_INST_ADDR,
    parameter int STALL_TIMEOUT = 256
) (
    input logic       i_clk,
    input logic       i_rst,
    pipe_ctrl_if.slave bus
);
    typedef enum logic {S_RUN, S_FLUSH} state_t;
    localparam logic [15:0] WD_LAST = 16'(STALL_TIMEOUT - 1);
    state_t                 state_q;
    logic                   flush_q;
    logic [N_INST_ADDR-1:0] new_pc_q;
    logic                   timeout_q, timeout_d;
    logic [15:0]            wd_q, wd_d;
    logic [5:0]             stall;
    always_comb begin
        stall = (i_rst || state_q == S_FLUSH) ? 6'b000000 :
                bus.i_stallreq_mem ? 6'b011111 :
                bus.i_stallreq_ex  ? 6'b001111 :
                bus.i_stallreq_id  ? 6'b000111 :
                bus.i_stallreq_if  ? 6'b000011 : 6'b000000;
        timeout_d = (stall != '0) && (wd_q == WD_LAST);
        wd_d = (stall == '0 || wd_q == WD_LAST) ? 16'd0 : wd_q + 16'd1;
    end
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= S_RUN;
            flush_q   <= 1'b0;
            new_pc_q  <= '0;
            timeout_q <= 1'b0;
            wd_q      <= '0;
        end else begin
            state_q   <= bus.i_flush_req ? S_FLUSH : S_RUN;
            flush_q   <= bus.i_flush_req;
            new_pc_q  <= bus.i_flush_req ? bus.i_flush_pc : new_pc_q;
            timeout_q <= timeout_d;
            wd_q      <= wd_d;
        end
    end
    assign bus.o_stall         = stall;
    assign bus.o_flush         = flush_q;
    assign bus.o_new_pc        = new_pc_q;
    assign bus.o_stall_timeout = timeout_q;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_q;
    always_ff @(posedge i_clk) begin
        if (i_rst || bus.i_perf_clr)
            perf_q <= '0;
        else if (stall != '0 && perf_q != 32'hFFFF_FFFF)
            perf_q <= perf_q + 32'd1;
    end
    assign bus.o_perf_stall_cnt = perf_q;
`else
    logic unused_perf_clr;
    assign unused_perf_clr      = bus.i_perf_clr;
    assign bus.o_perf_stall_cnt = '0;
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: vector table, watchdog/perf sequences and randomized model check for pipe_ctrl.
module tb_pipe_ctrl;
    localparam int T = 4;
`ifdef PIPE_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif
    logic i_clk = 1'b0;
    logic i_rst = 1'b1;
    always #5 i_clk = ~i_clk;

    pipe_ctrl_if #(.N_INST_ADDR(32)) bus ();
    pipe_ctrl #(.N_INST_ADDR(32), .STALL_TIMEOUT(T)) dut (.i_clk(i_clk), .i_rst(i_rst), .bus(bus.slave));

    int tests = 0;
    int fails = 0;
    bit          m_flush = 1'b0;
    logic [31:0] m_pc    = '0;
    int          m_run   = 0;
    bit          m_to    = 1'b0;
    logic [31:0] m_perf  = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // req = {mem, ex, id, if}; st returns the observed o_stall of this cycle
    task automatic cyc(input bit rst, input logic [3:0] req, input bit fr, input logic [31:0] pc,
                       input bit clr, output logic [5:0] st);
        int lvl;
        logic [5:0] exp_st;
        @(negedge i_clk);
        i_rst = rst;
        {bus.i_stallreq_mem, bus.i_stallreq_ex, bus.i_stallreq_id, bus.i_stallreq_if} = req;
        bus.i_flush_req = fr;
        bus.i_flush_pc  = pc;
        bus.i_perf_clr  = clr;
        #1;
        lvl = req[3] ? 5 : req[2] ? 4 : req[1] ? 3 : req[0] ? 2 : 0;
        exp_st = (rst || m_flush) ? 6'd0 : 6'((1 << lvl) - 1);
        st = bus.o_stall;
        chk("stall", {26'd0, bus.o_stall}, {26'd0, exp_st});
        if (rst) begin
            m_flush = 0; m_pc = '0; m_run = 0; m_to = 0; m_perf = '0;
        end else begin
            m_flush = fr;
            if (fr) m_pc = pc;
            if (exp_st != 0) begin
                m_run++;
                m_to = (m_run % T) == 0;
            end else begin
                m_run = 0;
                m_to  = 0;
            end
            if (PERF)
                m_perf = clr ? 32'd0 : (exp_st != 0 && m_perf != 32'hFFFF_FFFF) ? m_perf + 1 : m_perf;
        end
        @(posedge i_clk);
        #1;
        chk("flush", {31'd0, bus.o_flush}, {31'd0, m_flush});
        chk("new_pc", bus.o_new_pc, m_pc);
        chk("timeout", {31'd0, bus.o_stall_timeout}, {31'd0, m_to});
        chk("perf", bus.o_perf_stall_cnt, m_perf);
    endtask

    typedef struct {
        bit          rst;
        logic [3:0]  req;
        bit          fr;
        logic [31:0] pc;
        logic [5:0]  st;
        bit          fl;
        logic [31:0] npc;
    } vec_t;
    vec_t tbl[13];

    initial begin
        logic [5:0] st;
        bus.i_stallreq_if = 0; bus.i_stallreq_id = 0; bus.i_stallreq_ex = 0; bus.i_stallreq_mem = 0;
        bus.i_flush_req = 0; bus.i_flush_pc = '0; bus.i_perf_clr = 0;
        tbl[0]  = '{1, 4'b1111, 1, 32'hABC, 6'b000000, 0, 32'h0};
        tbl[1]  = '{0, 4'b0100, 0, 32'h0,   6'b001111, 0, 32'h0};
        tbl[2]  = '{0, 4'b1001, 0, 32'h0,   6'b011111, 0, 32'h0};
        tbl[3]  = '{0, 4'b0001, 0, 32'h0,   6'b000011, 0, 32'h0};
        tbl[4]  = '{0, 4'b0000, 1, 32'h380, 6'b000000, 1, 32'h380};
        tbl[5]  = '{0, 4'b0010, 0, 32'h0,   6'b000000, 0, 32'h380};
        tbl[6]  = '{0, 4'b0000, 0, 32'h0,   6'b000000, 0, 32'h380};
        tbl[7]  = '{0, 4'b0000, 1, 32'h100, 6'b000000, 1, 32'h100};
        tbl[8]  = '{0, 4'b1000, 1, 32'h200, 6'b000000, 1, 32'h200};
        tbl[9]  = '{0, 4'b0000, 0, 32'h0,   6'b000000, 0, 32'h200};
        tbl[10] = '{0, 4'b0100, 1, 32'h44,  6'b001111, 1, 32'h44};
        tbl[11] = '{1, 4'b0000, 0, 32'h0,   6'b000000, 0, 32'h0};
        tbl[12] = '{0, 4'b0000, 0, 32'h0,   6'b000000, 0, 32'h0};
        for (int i = 0; i < 13; i++) begin
            cyc(tbl[i].rst, tbl[i].req, tbl[i].fr, tbl[i].pc, 1'b0, st);
            chk($sformatf("tbl%0d_stall", i), {26'd0, st}, {26'd0, tbl[i].st});
            chk($sformatf("tbl%0d_flush", i), {31'd0, bus.o_flush}, {31'd0, tbl[i].fl});
            chk($sformatf("tbl%0d_pc", i), bus.o_new_pc, tbl[i].npc);
        end
        // watchdog: pulses follow stall cycles 4 and 8 only
        cyc(1, 4'b0000, 0, 0, 0, st);
        for (int k = 1; k <= 10; k++) begin
            cyc(0, 4'b0010, 0, 0, 0, st);
            chk($sformatf("wd_cycle%0d", k), {31'd0, bus.o_stall_timeout}, {31'd0, (k == 4 || k == 8)});
        end
        cyc(0, 4'b0000, 0, 0, 0, st);
        chk("wd_release", {31'd0, bus.o_stall_timeout}, 32'd0);
        for (int k = 1; k <= 3; k++) cyc(0, 4'b0010, 0, 0, 0, st);
        chk("wd_cleared", {31'd0, bus.o_stall_timeout}, 32'd0);
        // perf counter: 7 stalled cycles, then clear during a stall
        cyc(1, 4'b0000, 0, 0, 0, st);
        for (int k = 0; k < 7; k++) cyc(0, 4'b1000, 0, 0, 0, st);
        chk("perf_seven", bus.o_perf_stall_cnt, PERF ? 32'd7 : 32'd0);
        cyc(0, 4'b0001, 0, 0, 1, st);
        chk("perf_clr", bus.o_perf_stall_cnt, 32'd0);
        // randomized traffic against the model
        for (int k = 0; k < 400; k++) begin
            cyc($urandom_range(0, 19) == 0, 4'($urandom), $urandom_range(0, 3) == 0,
                $urandom, $urandom_range(0, 15) == 0, st);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
